// File: rtl/cva6v_config_pkg.sv
// rtl/cva6v_config_pkg.sv - minimal core configuration and RVFI record type
package cva6v_config_pkg;

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [31:0] pc;
    logic [31:0] insn;
  } rvfi_instr_t;

endpackage

// File: rtl/rvfi_commit_serializer_if.sv
// rtl/rvfi_commit_serializer_if.sv - single-record output stream of the commit serializer
interface rvfi_commit_serializer_if #(
  parameter type         rec_t  = logic,
  parameter int unsigned PORT_W = 1,
  parameter int unsigned SEQ_W  = 32
);
  logic              out_valid_o;
  logic              out_ready_i;
  rec_t              out_rec_o;
  logic [PORT_W-1:0] out_port_o;
  logic [SEQ_W-1:0]  out_seq_o;

  modport master (
    output out_valid_o, out_rec_o, out_port_o, out_seq_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_rec_o, out_port_o, out_seq_o,
    output out_ready_i
  );
endinterface

// File: rtl/rvfi_commit_serializer.sv
// rtl/rvfi_commit_serializer.sv - compacts multi-port RVFI commits into an in-order FIFO
// and drains one sequence-tagged record per cycle.
module rvfi_commit_serializer #(
  parameter cva6v_config_pkg::cva6_cfg_t CVA6Cfg = cva6v_config_pkg::cva6_cfg_empty,
  parameter type         rvfi_instr_t = cva6v_config_pkg::rvfi_instr_t,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SEQ_W        = 32,
  localparam int unsigned NP          = CVA6Cfg.NrCommitPorts,
  localparam int unsigned PORT_W      = (NP > 1) ? $clog2(NP) : 1,
  localparam int unsigned LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  rvfi_instr_t [NP-1:0]    rvfi_i,
  input  logic                    flush_i,
  rvfi_commit_serializer_if.master out_if,
  output logic [LVL_W-1:0]        level_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(NP + 1);

  rvfi_instr_t       rec_mem_q  [DEPTH];
  logic [PORT_W-1:0] port_mem_q [DEPTH];
  logic [SEQ_W-1:0]  seq_mem_q  [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [NP-1:0]    live;
  logic [CNT_W-1:0] offset [NP];
  logic [PTR_W-1:0] slot   [NP];
  logic [CNT_W-1:0] n_live;
  logic [LVL_W:0]   space;
  logic [16:0]      drop_sum;
  logic             pop, push, drop;

  // Each live port's slot offset is the number of live ports below it.
  always_comb begin
    n_live = '0;
    for (int i = 0; i < int'(NP); i++) begin
      live[i]   = rvfi_i[i].valid | rvfi_i[i].trap;
      offset[i] = n_live;
      slot[i]   = wptr_q + PTR_W'(offset[i]);
      n_live    = n_live + CNT_W'(live[i]);
    end
  end

  assign pop   = out_if.out_valid_o & out_if.out_ready_i;
  assign space = (LVL_W+1)'(DEPTH) - {1'b0, level_q} + (LVL_W+1)'(pop);
  assign push  = !flush_i && (n_live != '0) && ((LVL_W+1)'(n_live) <= space);
  assign drop  = !flush_i && ((LVL_W+1)'(n_live) > space);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    seq_d      = seq_q + SEQ_W'(n_live);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_live);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(n_live);
      if (pop)  rptr_d = rptr_q + 1'b1;
      level_d = level_q + (push ? LVL_W'(n_live) : '0) - LVL_W'(pop);
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        rec_mem_q[j]  <= '0;
        port_mem_q[j] <= '0;
        seq_mem_q[j]  <= '0;
      end
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      // Only free slots are written, so a stalled head is never overwritten.
      if (push) begin
        for (int i = 0; i < int'(NP); i++) begin
          if (live[i]) begin
            rec_mem_q[slot[i]]  <= rvfi_i[i];
            port_mem_q[slot[i]] <= PORT_W'(i);
            seq_mem_q[slot[i]]  <= seq_q + SEQ_W'(offset[i]);
          end
        end
      end
    end
  end

  assign out_if.out_valid_o = (level_q != '0);
  assign out_if.out_rec_o   = rec_mem_q[rptr_q];
  assign out_if.out_port_o  = port_mem_q[rptr_q];
  assign out_if.out_seq_o   = seq_mem_q[rptr_q];
  assign level_o            = level_q;
  assign overflow_o         = overflow_q;
  assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// tb/tb_rvfi_commit_serializer.sv - directed self-checking bench, NP=2, DEPTH=8
module tb_rvfi_commit_serializer;
  import cva6v_config_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  rvfi_instr_t [1:0] rvfi;
  logic [3:0]        level;
  logic              overflow;
  logic [15:0]       drop_cnt;
  int                tests_run = 0;
  int                tests_failed = 0;

  rvfi_commit_serializer_if #(.rec_t(rvfi_instr_t), .PORT_W(1), .SEQ_W(32)) out_if ();

  rvfi_commit_serializer #(.DEPTH(8), .SEQ_W(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rvfi_i     (rvfi),
    .flush_i    (flush),
    .out_if     (out_if),
    .level_o    (level),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic t, input logic [31:0] pc);
    rvfi[p].valid = v;
    rvfi[p].trap  = t;
    rvfi[p].pc    = pc;
    rvfi[p].insn  = pc ^ 32'h13;
  endtask

  task automatic clear_ports();
    rvfi = '0;
  endtask

  task automatic push_both(input logic [31:0] pc0, input logic [31:0] pc1);
    drive(0, 1'b1, 1'b0, pc0);
    drive(1, 1'b1, 1'b0, pc1);
    step();
    clear_ports();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_if.out_ready_i = 1'b0;
    clear_ports();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_if.out_ready_i = 1'b0;
    clear_ports();
    step();
    tests_run++; if (out_if.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", out_if.out_valid_o); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
    tests_run++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_drop: got ovf %0b cnt %0d want 0 0", overflow, drop_cnt); end
    tests_run++; if (out_if.out_seq_o !== 32'd0 || out_if.out_port_o !== 1'b0) begin tests_failed++; $display("FAIL reset_head: got seq %0d port %0d want 0 0", out_if.out_seq_o, out_if.out_port_o); end
    rst_n = 1'b1;
    step();
    push_both(32'h10, 32'h14);
    push_both(32'h18, 32'h1C);
    drive(0, 1'b1, 1'b0, 32'h20);
    step();
    clear_ports();
    tests_run++; if (level !== 4'd5) begin tests_failed++; $display("FAIL midstream_level: got %0d want 5", level); end
    #3 rst_n = 1'b0;
    #1;
    tests_run++; if (out_if.out_valid_o !== 1'b0 || level !== 4'd0 || drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL async_reset: got valid %0b level %0d cnt %0d want 0 0 0", out_if.out_valid_o, level, drop_cnt); end
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h40);
    step();
    clear_ports();
    tests_run++; if (out_if.out_valid_o !== 1'b1 || out_if.out_seq_o !== 32'd0 || out_if.out_rec_o.pc !== 32'h40) begin tests_failed++; $display("FAIL reset_first_seq: got valid %0b seq %0d pc %0h want 1 0 40", out_if.out_valid_o, out_if.out_seq_o, out_if.out_rec_o.pc); end
  endtask

  task automatic test_compaction();
    do_reset();
    out_if.out_ready_i = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h80000000);
    drive(1, 1'b1, 1'b0, 32'h80000004);
    step();
    clear_ports();
    drive(1, 1'b1, 1'b0, 32'h80000008);
    tests_run++; if (out_if.out_port_o !== 1'b0 || out_if.out_seq_o !== 32'd0 || out_if.out_rec_o.pc !== 32'h80000000) begin tests_failed++; $display("FAIL compact_first: got port %0d seq %0d pc %0h want 0 0 80000000", out_if.out_port_o, out_if.out_seq_o, out_if.out_rec_o.pc); end
    tests_run++; if (level !== 4'd2) begin tests_failed++; $display("FAIL compact_level: got %0d want 2", level); end
    step();
    clear_ports();
    tests_run++; if (out_if.out_port_o !== 1'b1 || out_if.out_seq_o !== 32'd1 || out_if.out_rec_o.pc !== 32'h80000004) begin tests_failed++; $display("FAIL compact_second: got port %0d seq %0d pc %0h want 1 1 80000004", out_if.out_port_o, out_if.out_seq_o, out_if.out_rec_o.pc); end
    step();
    tests_run++; if (out_if.out_port_o !== 1'b1 || out_if.out_seq_o !== 32'd2 || out_if.out_rec_o.pc !== 32'h80000008) begin tests_failed++; $display("FAIL compact_port1_only: got port %0d seq %0d pc %0h want 1 2 80000008", out_if.out_port_o, out_if.out_seq_o, out_if.out_rec_o.pc); end
    step();
    tests_run++; if (out_if.out_valid_o !== 1'b0 || level !== 4'd0) begin tests_failed++; $display("FAIL compact_drained: got valid %0b level %0d want 0 0", out_if.out_valid_o, level); end
  endtask

  task automatic test_trap();
    do_reset();
    drive(0, 1'b0, 1'b1, 32'h100);
    step();
    clear_ports();
    tests_run++; if (level !== 4'd1 || out_if.out_rec_o.trap !== 1'b1 || out_if.out_rec_o.valid !== 1'b0 || out_if.out_seq_o !== 32'd0) begin tests_failed++; $display("FAIL trap_capture: got level %0d trap %0b valid %0b seq %0d want 1 1 0 0", level, out_if.out_rec_o.trap, out_if.out_rec_o.valid, out_if.out_seq_o); end
    step();
    tests_run++; if (level !== 4'd1) begin tests_failed++; $display("FAIL trap_idle: got level %0d want 1", level); end
    drive(1, 1'b1, 1'b0, 32'h200);
    step();
    clear_ports();
    out_if.out_ready_i = 1'b1;
    step();
    tests_run++; if (out_if.out_seq_o !== 32'd1 || out_if.out_port_o !== 1'b1 || out_if.out_rec_o.pc !== 32'h200) begin tests_failed++; $display("FAIL trap_seq_after_idle: got seq %0d port %0d pc %0h want 1 1 200", out_if.out_seq_o, out_if.out_port_o, out_if.out_rec_o.pc); end
  endtask

  task automatic test_overflow();
    int exp_seq [8] = '{0, 1, 2, 3, 4, 5, 6, 9};
    do_reset();
    push_both(32'h0, 32'h4);
    push_both(32'h8, 32'hC);
    push_both(32'h10, 32'h14);
    drive(0, 1'b1, 1'b0, 32'h18);
    step();
    clear_ports();
    tests_run++; if (level !== 4'd7) begin tests_failed++; $display("FAIL ovf_fill: got level %0d want 7", level); end
    push_both(32'h1C, 32'h20);
    tests_run++; if (level !== 4'd7 || drop_cnt !== 16'd2 || overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_drop: got level %0d cnt %0d ovf %0b want 7 2 1", level, drop_cnt, overflow); end
    drive(0, 1'b1, 1'b0, 32'h24);
    step();
    clear_ports();
    tests_run++; if (level !== 4'd8 || drop_cnt !== 16'd2) begin tests_failed++; $display("FAIL ovf_last_slot: got level %0d cnt %0d want 8 2", level, drop_cnt); end
    out_if.out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (out_if.out_valid_o !== 1'b1 || out_if.out_seq_o !== 32'(exp_seq[k])) begin tests_failed++; $display("FAIL ovf_drain_%0d: got valid %0b seq %0d want 1 %0d", k, out_if.out_valid_o, out_if.out_seq_o, exp_seq[k]); end
      step();
    end
    tests_run++; if (out_if.out_valid_o !== 1'b0 || overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got valid %0b ovf %0b want 0 1", out_if.out_valid_o, overflow); end
  endtask

  task automatic test_full_plus_pop();
    do_reset();
    push_both(32'h0, 32'h4);
    push_both(32'h8, 32'hC);
    push_both(32'h10, 32'h14);
    push_both(32'h18, 32'h1C);
    tests_run++; if (level !== 4'd8) begin tests_failed++; $display("FAIL full_level: got %0d want 8", level); end
    out_if.out_ready_i = 1'b1;
    drive(0, 1'b1, 1'b0, 32'hABC);
    step();
    clear_ports();
    tests_run++; if (level !== 4'd8 || drop_cnt !== 16'd0 || overflow !== 1'b0 || out_if.out_seq_o !== 32'd1) begin tests_failed++; $display("FAIL full_pop_push: got level %0d cnt %0d ovf %0b seq %0d want 8 0 0 1", level, drop_cnt, overflow, out_if.out_seq_o); end
    out_if.out_ready_i = 1'b0;
    drive(1, 1'b1, 1'b0, 32'hDEF);
    step();
    clear_ports();
    tests_run++; if (level !== 4'd8 || drop_cnt !== 16'd1 || overflow !== 1'b1 || out_if.out_seq_o !== 32'd1) begin tests_failed++; $display("FAIL full_no_pop: got level %0d cnt %0d ovf %0b seq %0d want 8 1 1 1", level, drop_cnt, overflow, out_if.out_seq_o); end
  endtask

  task automatic test_flush_backpressure();
    logic [5:0]  pat = 6'b010010;
    int          pops = 0;
    logic [31:0] prev_seq, prev_pc;
    do_reset();
    push_both(32'h1000, 32'h1004);
    push_both(32'h1008, 32'h100C);
    for (int c = 0; c < 6; c++) begin
      out_if.out_ready_i = pat[c];
      prev_seq = out_if.out_seq_o;
      prev_pc  = out_if.out_rec_o.pc;
      step();
      if (pat[c]) pops++;
      tests_run++; if (out_if.out_seq_o !== 32'(pops) || out_if.out_rec_o.pc !== 32'(32'h1000 + 4 * pops)) begin tests_failed++; $display("FAIL bp_head_%0d: got seq %0d pc %0h want %0d %0h", c, out_if.out_seq_o, out_if.out_rec_o.pc, pops, 32'h1000 + 4 * pops); end
      if (!pat[c]) begin
        tests_run++; if (out_if.out_seq_o !== prev_seq || out_if.out_rec_o.pc !== prev_pc) begin tests_failed++; $display("FAIL bp_stable_%0d: got seq %0d pc %0h want %0d %0h", c, out_if.out_seq_o, out_if.out_rec_o.pc, prev_seq, prev_pc); end
      end
    end
    out_if.out_ready_i = 1'b0;
    tests_run++; if (level !== 4'd2) begin tests_failed++; $display("FAIL bp_level: got %0d want 2", level); end
    push_both(32'h1010, 32'h1014);
    flush = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h2000);
    step();
    flush = 1'b0;
    clear_ports();
    tests_run++; if (level !== 4'd0 || out_if.out_valid_o !== 1'b0 || drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL flush_clear: got level %0d valid %0b cnt %0d want 0 0 0", level, out_if.out_valid_o, drop_cnt); end
    drive(0, 1'b1, 1'b0, 32'h3000);
    step();
    clear_ports();
    tests_run++; if (out_if.out_valid_o !== 1'b1 || out_if.out_seq_o !== 32'd7 || out_if.out_rec_o.pc !== 32'h3000 || level !== 4'd1) begin tests_failed++; $display("FAIL flush_next_seq: got valid %0b seq %0d pc %0h level %0d want 1 7 3000 1", out_if.out_valid_o, out_if.out_seq_o, out_if.out_rec_o.pc, level); end
  endtask

  initial begin
    out_if.out_ready_i = 1'b0;
    clear_ports();
    test_reset();
    test_compaction();
    test_trap();
    test_overflow();
    test_full_plus_pop();
    test_flush_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
